// File: rtl/ball_paddle_ctrl.sv
// ball_paddle_ctrl: once-per-frame paddle/ball physics with serve, bounce, miss and lives; define PADDLE_ENGLISH_EN to let the paddle hit zone steer the ball
module ball_paddle_ctrl #(
  parameter int BALL_SIZE    = 7,
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_W     = 100,
  parameter int PADDLE_Y     = 440,
  parameter int PADDLE_SPEED = 4,
  parameter int LIVES        = 3,
  parameter int MISS_FRAMES  = 60
) (
  input  logic       CLK_25MH,
  input  logic       reset,
  input  logic [9:0] hor_count,
  input  logic [9:0] ver_count,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       launch,
  output logic [9:0] paddle_pos,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [2:0] lives,
  output logic       life_lost,
  output logic       game_over
);
  localparam int CW = $clog2(MISS_FRAMES + 1);
  localparam logic [10:0] BS = 11'(BALL_SIZE);
  localparam logic [10:0] BH = 11'(BALL_SIZE / 2);
  localparam logic [10:0] BV = 11'(BALL_SPEED);
  localparam logic [10:0] PW = 11'(PADDLE_W);
  localparam logic [10:0] PW3 = 11'(PADDLE_W / 3);
  localparam logic [10:0] PW23 = 11'(2 * PADDLE_W / 3);
  localparam logic [10:0] PY = 11'(PADDLE_Y);
  localparam logic [10:0] PV = 11'(PADDLE_SPEED);
  localparam logic [10:0] P_MAX = 11'(640 - PADDLE_W);
  localparam logic [10:0] X_MAX = 11'(639 - BALL_SIZE);
  localparam logic [10:0] Y_MISS = 11'(479 - BALL_SIZE);
  localparam logic [10:0] SERVE_OFF = 11'(PADDLE_W / 2 - (BALL_SIZE + 1) / 2);
  localparam logic [9:0] SERVE_Y = 10'(PADDLE_Y - BALL_SIZE - 1);
  localparam logic [9:0] HOME_P = 10'((640 - PADDLE_W) / 2);
  localparam logic [9:0] HOME_X = 10'((640 - PADDLE_W) / 2 + PADDLE_W / 2 - (BALL_SIZE + 1) / 2);
  typedef enum logic [1:0] {SERVE, PLAY, MISS, GAME_OVER} state_t;
  state_t state;
  logic [1:0] left_s, right_s, launch_s;
  logic frame_tick, dx, dy;
  logic [CW-1:0] miss_cnt;
  logic [10:0] px, bx, by;
  logic [9:0] pad_nx, serve_x, bx_nx, by_nx;
  logic go_l, go_r, wall_l, wall_r, top, hit, missed, dx_nx, dy_nx;
  // Next paddle position and next ball motion for the coming tick (dx/dy high = right/down)
  always_comb begin
    px = {1'b0, paddle_pos};
    bx = {1'b0, ball_x};
    by = {1'b0, ball_y};
    go_l = left_s[1] && !right_s[1];
    go_r = right_s[1] && !left_s[1];
    pad_nx = go_l ? (px < PV ? 10'd0 : 10'(px - PV)) : go_r ? (px + PV > P_MAX ? P_MAX[9:0] : 10'(px + PV)) : paddle_pos;
    serve_x = 10'({1'b0, pad_nx} + SERVE_OFF);
    wall_r = dx && bx + BV >= X_MAX;
    wall_l = !dx && bx < BV;
    top = !dy && by < BV;
    hit = dy && by + BS + BV >= PY && by <= PY && bx + BS >= px && bx <= px + PW;
    missed = dy && !hit && by + BV >= Y_MISS;
    bx_nx = wall_r ? X_MAX[9:0] : wall_l ? 10'd0 : 10'(dx ? bx + BV : bx - BV);
    by_nx = top ? 10'd0 : hit ? SERVE_Y : 10'(dy ? by + BV : by - BV);
    dy_nx = top || (dy && !hit);
`ifdef PADDLE_ENGLISH_EN
    dx_nx = (wall_r || wall_l) ? !dx : !hit ? dx : bx + BH < px + PW3 ? 1'b0 : bx + BH >= px + PW23 ? 1'b1 : dx;
`else
    dx_nx = dx ^ (wall_r || wall_l);
`endif
  end
  // Two-flop synchronisers for the raw buttons and the start-of-vblank frame strobe
  always_ff @(posedge CLK_25MH or posedge reset)
    if (reset) begin
      left_s <= '0;
      right_s <= '0;
      launch_s <= '0;
      frame_tick <= 1'b0;
    end else begin
      left_s <= {left_s[0], btn_left};
      right_s <= {right_s[0], btn_right};
      launch_s <= {launch_s[0], launch};
      frame_tick <= hor_count == 10'd0 && ver_count == 10'd480;
    end
  // Game state machine: paddle, ball, lives and flags advance once per frame tick
  always_ff @(posedge CLK_25MH or posedge reset)
    if (reset) begin
      state <= SERVE;
      paddle_pos <= HOME_P;
      ball_x <= HOME_X;
      ball_y <= SERVE_Y;
      dx <= 1'b1;
      dy <= 1'b0;
      lives <= 3'(LIVES);
      life_lost <= 1'b0;
      game_over <= 1'b0;
      miss_cnt <= '0;
    end else begin
      life_lost <= 1'b0;
      if (frame_tick && state != GAME_OVER) begin
        paddle_pos <= pad_nx;
        case (state)
          SERVE: begin
            ball_x <= serve_x;
            ball_y <= SERVE_Y;
            if (launch_s[1]) begin
              state <= PLAY;
              dx <= 1'b1;
              dy <= 1'b0;
            end
          end
          PLAY:
            if (missed) begin
              life_lost <= 1'b1;
              lives <= lives - 3'd1;
              game_over <= lives == 3'd1;
              state <= lives == 3'd1 ? GAME_OVER : MISS;
            end else begin
              ball_x <= bx_nx;
              ball_y <= by_nx;
              dx <= dx_nx;
              dy <= dy_nx;
            end
          MISS:
            if (miss_cnt == CW'(MISS_FRAMES - 1)) begin
              miss_cnt <= '0;
              ball_x <= serve_x;
              ball_y <= SERVE_Y;
              dx <= 1'b1;
              dy <= 1'b0;
              state <= SERVE;
            end else begin
              miss_cnt <= miss_cnt + 1'b1;
            end
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_ball_paddle_ctrl.sv
// tb_ball_paddle_ctrl: directed frame-by-frame vectors for ball_paddle_ctrl with hand-derived trajectories
module tb_ball_paddle_ctrl;
  logic CLK_25MH = 1'b0;
  logic reset = 1'b0;
  logic [9:0] hor_count = 10'd100;
  logic [9:0] ver_count = 10'd100;
  logic btn_left = 1'b0;
  logic btn_right = 1'b0;
  logic launch = 1'b0;
  logic [9:0] paddle_pos, ball_x, ball_y;
  logic [2:0] lives;
  logic life_lost, game_over;
  int vectors = 0;
  int miscompares = 0;
  ball_paddle_ctrl dut (
    .CLK_25MH(CLK_25MH),
    .reset(reset),
    .hor_count(hor_count),
    .ver_count(ver_count),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .launch(launch),
    .paddle_pos(paddle_pos),
    .ball_x(ball_x),
    .ball_y(ball_y),
    .lives(lives),
    .life_lost(life_lost),
    .game_over(game_over)
  );
  always #20 CLK_25MH = ~CLK_25MH;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic check_ball(input string tag, input int x, input int y);
    check({tag, ".x"}, ball_x, x);
    check({tag, ".y"}, ball_y, y);
  endtask
  // One frame: counter match for a single cycle, then the tick cycle, outputs settled at the last negedge
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge CLK_25MH);
      hor_count = 10'd0;
      ver_count = 10'd480;
      @(negedge CLK_25MH);
      ver_count = 10'd0;
      @(negedge CLK_25MH);
    end
  endtask
  task automatic buttons(input logic l, input logic r, input logic la);
    btn_left = l;
    btn_right = r;
    launch = la;
    repeat (3) @(negedge CLK_25MH);
  endtask
  // Asynchronous reset asserted mid-cycle while a frame match is pending
  task automatic pulse_reset(input string tag);
    @(negedge CLK_25MH);
    hor_count = 10'd0;
    ver_count = 10'd480;
    #7 reset = 1'b1;
    #1;
    check({tag, ".paddle"}, paddle_pos, 270);
    check_ball(tag, 316, 432);
    check({tag, ".lives"}, lives, 3);
    check({tag, ".life_lost"}, life_lost, 0);
    check({tag, ".game_over"}, game_over, 0);
    @(negedge CLK_25MH);
    ver_count = 10'd100;
    hor_count = 10'd100;
    reset = 1'b0;
    @(negedge CLK_25MH);
  endtask
  // Serve from paddle 270 and let the ball fall past the paddle (453rd play tick)
  task automatic serve_to_miss(input string tag, input int lives_exp, input int over_exp);
    buttons(1'b0, 1'b0, 1'b1);
    tick(1);
    buttons(1'b0, 1'b0, 1'b0);
    tick(452);
    check({tag, ".pre_pulse"}, life_lost, 0);
    tick(1);
    check({tag, ".pulse"}, life_lost, 1);
    check({tag, ".lives"}, lives, lives_exp);
    check({tag, ".game_over"}, game_over, over_exp);
    @(negedge CLK_25MH);
    check({tag, ".pulse_end"}, life_lost, 0);
  endtask
  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge CLK_25MH);
    check("rst.paddle", paddle_pos, 270);
    check_ball("rst", 316, 432);
    check("rst.lives", lives, 3);
    check("rst.life_lost", life_lost, 0);
    check("rst.game_over", game_over, 0);
    reset = 1'b0;
    buttons(1'b0, 1'b1, 1'b0);
    tick(10);
    check("right10.paddle", paddle_pos, 310);
    check_ball("right10", 356, 432);
    tick(190);
    check("right200.paddle", paddle_pos, 540);
    check("right200.ball_x", ball_x, 586);
    tick(5);
    check("right_hold.paddle", paddle_pos, 540);
    buttons(1'b1, 1'b1, 1'b0);
    tick(3);
    check("both.paddle", paddle_pos, 540);
    buttons(1'b1, 1'b0, 1'b0);
    tick(140);
    check("left_clamp.paddle", paddle_pos, 0);
    check("left_clamp.ball_x", ball_x, 46);
    buttons(1'b0, 1'b1, 1'b0);
    tick(38);
    check("p152.paddle", paddle_pos, 152);
    buttons(1'b0, 1'b0, 1'b1);
    tick(1);
    check_ball("launch152", 198, 432);
    buttons(1'b0, 1'b0, 1'b0);
    tick(216);
    check_ball("pre_corner", 630, 0);
    tick(1);
    check_ball("corner", 632, 0);
    tick(1);
    check_ball("post_corner", 630, 2);
    pulse_reset("midreset");
    buttons(1'b0, 1'b0, 1'b1);
    tick(1);
    check_ball("launch", 316, 432);
    buttons(1'b0, 1'b0, 1'b0);
    tick(1);
    check_ball("first_move", 318, 430);
    tick(156);
    check_ball("pre_wall", 630, 118);
    tick(1);
    check_ball("wall_r", 632, 116);
    tick(1);
    check_ball("post_wall", 630, 114);
    tick(293);
    check_ball("pre_miss", 44, 470);
    check("pre_miss.pulse", life_lost, 0);
    tick(1);
    check("miss1.pulse", life_lost, 1);
    check("miss1.lives", lives, 2);
    check("miss1.game_over", game_over, 0);
    @(negedge CLK_25MH);
    check("miss1.pulse_end", life_lost, 0);
    buttons(1'b0, 1'b0, 1'b1);
    tick(59);
    check_ball("miss_frozen", 44, 470);
    tick(1);
    check_ball("miss_reserve", 316, 432);
    buttons(1'b0, 1'b0, 1'b0);
    tick(1);
    check_ball("serve_idle", 316, 432);
    serve_to_miss("miss2", 1, 0);
    tick(60);
    check_ball("miss2_reserve", 316, 432);
    serve_to_miss("miss3", 0, 1);
    buttons(1'b1, 1'b0, 1'b1);
    tick(5);
    check("over.paddle", paddle_pos, 270);
    check_ball("over", 44, 470);
    check("over.lives", lives, 0);
    check("over.game_over", game_over, 1);
    buttons(1'b0, 1'b0, 1'b0);
    pulse_reset("over_reset");
    buttons(1'b0, 1'b0, 1'b1);
    tick(1);
    buttons(1'b1, 1'b0, 1'b0);
    tick(65);
    check("eng.paddle", paddle_pos, 10);
    buttons(1'b0, 1'b0, 1'b0);
    tick(368);
    check_ball("eng_pre_hit", 82, 432);
    tick(1);
    check_ball("eng_hit", 80, 432);
    check("eng_hit.lives", lives, 3);
    tick(1);
`ifdef PADDLE_ENGLISH_EN
    check_ball("eng_after", 82, 430);
`else
    check_ball("eng_after", 78, 430);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
